// File: rtl/inert_disp_sel.sv
// inert_disp_sel: calibration handshake, NUM_CH-channel sample buffer and a
// windowed LED view of the selected channel with manual or automatic stepping.
module inert_disp_sel #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 16,
  parameter int LED_W    = 8,
  parameter int SHIFT_W  = 4,
  parameter int AUTO_PER = 25000000,
  parameter int CAL_TMO  = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cal_done,
  input  logic                       vld,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       next,
  input  logic                       prev,
  input  logic                       auto_en,
  input  logic                       freeze,
  input  logic [SHIFT_W-1:0]         shift,
  output logic                       strt_cal,
  output logic [LED_W-1:0]           LED,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic                       cal_err
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int TMR_W   = (CAL_TMO > 2) ? $clog2(CAL_TMO) : 1;
  localparam int CNT_W   = $clog2(AUTO_PER);
  localparam int MAX_LSB = DATA_W - LED_W;

  typedef enum logic [1:0] {ST_CAL, ST_SHOW, ST_ERR} state_t;

  state_t                         state_reg, state_next;
  logic [TMR_W-1:0]               cal_tmr_reg, cal_tmr_next;
  logic [CNT_W-1:0]               auto_cnt_reg, auto_cnt_next;
  logic [CH_W-1:0]                ch_sel_reg, ch_sel_next;
  logic [CH_W-1:0]                ch_inc, ch_dec;
  logic                           strt_pend_reg, strt_cal_reg;
  logic [NUM_CH-1:0][DATA_W-1:0]  samp_reg;
  logic [DATA_W-1:0]              in_word [NUM_CH];
  logic [DATA_W-1:0]              sel_word;
  logic                           cal_tmo;
  logic                           capture;
  int                             win_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign in_word[gi] = ch_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_CAL;
    else        state_reg <= state_next;
  end

  // Next-state logic; cal_done has priority over the timeout
  assign cal_tmo = (cal_tmr_reg == TMR_W'(CAL_TMO - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CAL: begin
        if (cal_done)     state_next = ST_SHOW;
        else if (cal_tmo) state_next = ST_ERR;
      end
      ST_SHOW: state_next = ST_SHOW;
      ST_ERR:  if (next) state_next = ST_CAL;
      default: state_next = ST_CAL;
    endcase
  end

  // Output decode from registered state and sample buffer
  always_comb begin
    win_lsb  = (int'(shift) > MAX_LSB) ? MAX_LSB : int'(shift);
    sel_word = samp_reg[ch_sel_reg];
    LED      = '0;
    case (state_reg)
      ST_SHOW: LED = LED_W'(sel_word >> win_lsb);
      ST_ERR:  LED = '1;
      default: LED[LED_W-1] = 1'b1;
    endcase
  end

  assign cal_err  = (state_reg == ST_ERR);
  assign strt_cal = strt_cal_reg;
  assign ch_sel   = ch_sel_reg;

  assign ch_inc = (ch_sel_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_reg + CH_W'(1);
  assign ch_dec = (ch_sel_reg == '0) ? CH_W'(NUM_CH - 1) : ch_sel_reg - CH_W'(1);

  // A manual step always restarts the auto period and suppresses that cycle's auto step
  always_comb begin
    ch_sel_next   = ch_sel_reg;
    auto_cnt_next = '0;
    if (state_reg == ST_SHOW) begin
      if (next || prev) begin
        if (next && !prev)      ch_sel_next = ch_inc;
        else if (prev && !next) ch_sel_next = ch_dec;
      end else if (auto_en) begin
        if (auto_cnt_reg == CNT_W'(AUTO_PER - 1)) ch_sel_next = ch_inc;
        else                                      auto_cnt_next = auto_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cal_tmr_next = (state_reg == ST_CAL && state_next == ST_CAL) ?
                        cal_tmr_reg + TMR_W'(1) : '0;
  assign capture      = (state_reg == ST_SHOW) && vld && !freeze;

  // strt_pend marks "just entered CAL"; it resets high so the first clock pulses strt_cal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_pend_reg <= 1'b1;
      strt_cal_reg  <= 1'b0;
      cal_tmr_reg   <= '0;
      auto_cnt_reg  <= '0;
      ch_sel_reg    <= '0;
    end else begin
      strt_pend_reg <= (state_reg == ST_ERR) && next;
      strt_cal_reg  <= strt_pend_reg;
      cal_tmr_reg   <= cal_tmr_next;
      auto_cnt_reg  <= auto_cnt_next;
      ch_sel_reg    <= ch_sel_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_reg <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_CH; k++) samp_reg[k] <= in_word[k];
    end
  end

endmodule

// File: tb/tb_inert_disp_sel.sv
// Randomized self-checking bench for inert_disp_sel against a cycle-level behavioural model.
module tb_inert_disp_sel;

  localparam int N        = 3;
  localparam int DW       = 16;
  localparam int AUTO_PER = 4;
  localparam int CAL_TMO  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cal_done, vld, next, prev, auto_en, freeze;
  logic [N*DW-1:0] ch_data;
  logic [3:0]  shift;
  logic        strt_cal, cal_err;
  logic [7:0]  LED;
  logic [1:0]  ch_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = calibrating, 1 = showing, 2 = error
  int m_mode, m_ch, m_cnt, m_edges;
  int m_buf [N];
  bit m_strt_due, m_strt;

  inert_disp_sel #(
    .NUM_CH(N), .DATA_W(DW), .LED_W(8), .SHIFT_W(4),
    .AUTO_PER(AUTO_PER), .CAL_TMO(CAL_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cal_done(cal_done), .vld(vld), .ch_data(ch_data),
    .next(next), .prev(prev), .auto_en(auto_en), .freeze(freeze), .shift(shift),
    .strt_cal(strt_cal), .LED(LED), .ch_sel(ch_sel), .cal_err(cal_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(string tag, int unsigned obs, int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned exp_led();
    int s;
    if (m_mode == 0) return 32'h80;
    if (m_mode == 2) return 32'hFF;
    s = (int'(shift) > 8) ? 8 : int'(shift);
    return (m_buf[m_ch] / (1 << s)) % 256;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ch = 0; m_cnt = 0; m_edges = 0;
    m_strt_due = 1'b1; m_strt = 1'b0;
    for (int k = 0; k < N; k++) m_buf[k] = 0;
  endtask

  task automatic model_edge();
    int d;
    m_strt     = m_strt_due;
    m_strt_due = 1'b0;
    case (m_mode)
      0: begin
        m_edges++;
        if (cal_done) begin
          m_mode = 1; m_ch = 0; m_cnt = 0;
        end else if (m_edges == CAL_TMO) begin
          m_mode = 2;
        end
      end
      1: begin
        if (vld && !freeze)
          for (int k = 0; k < N; k++) m_buf[k] = int'(ch_data[k*DW +: DW]);
        d = (next ? 1 : 0) - (prev ? 1 : 0);
        if (next || prev) begin
          m_ch  = (m_ch + d + N) % N;
          m_cnt = 0;
        end else if (auto_en) begin
          m_cnt++;
          if (m_cnt == AUTO_PER) begin
            m_ch  = (m_ch + 1) % N;
            m_cnt = 0;
          end
        end else begin
          m_cnt = 0;
        end
      end
      default: if (next) begin
        m_mode = 0; m_edges = 0; m_strt_due = 1'b1;
      end
    endcase
  endtask

  task automatic check_outputs(string tag);
    check_val({tag, ".led"},      LED,      exp_led());
    check_val({tag, ".ch_sel"},   ch_sel,   m_ch);
    check_val({tag, ".cal_err"},  cal_err,  (m_mode == 2) ? 1 : 0);
    check_val({tag, ".strt_cal"}, strt_cal, m_strt);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    cal_done = 0; vld = 0; next = 0; prev = 0; freeze = 0; auto_en = 0;
    ch_data = '0; shift = '0;
  endtask

  // Reset is asserted mid-cycle so its effect is checked before any clock edge
  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs({tag, ".async"});
    idle_inputs();
    repeat (2) @(negedge clk);
    check_outputs({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #3 check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Calibration handshake with cal_done in cycle 10
    for (int c = 1; c <= 10; c++) begin
      cal_done = (c == 10);
      step("cal_hs");
    end
    cal_done = 0;
    check_val("cal_hs.ch0", ch_sel, 0);
    $display("txn cal_handshake: ch_sel=%0d LED=0x%0h", ch_sel, LED);

    // Window select and clamping
    vld = 1; ch_data = {16'h0000, 16'h0000, 16'h01FE}; shift = 4'd1;
    step("win");
    vld = 0;
    check_val("win.shift1", LED, 8'hFF);
    shift = 4'd15;
    step("win");
    check_val("win.shift15", LED, 8'h01);
    $display("txn window: LED=0x%0h", LED);

    // Manual stepping
    shift = 4'd0;
    for (int i = 0; i < 4; i++) begin
      next = 1; step("next");
      next = 0;
      check_val("next.seq", ch_sel, (i + 1) % 3);
    end
    next = 1; step("next"); next = 1; step("next"); next = 0;
    prev = 1; step("prev"); prev = 0;
    check_val("prev.wrap", ch_sel, 2);
    next = 1; prev = 1; step("both"); next = 0; prev = 0;
    check_val("both.hold", ch_sel, 2);
    $display("txn manual_step: ch_sel=%0d", ch_sel);

    // Auto cycling with a manual step in between
    auto_en = 1;
    for (int i = 0; i < 10; i++) step("auto");
    next = 1; step("auto_next"); next = 0;
    for (int i = 0; i < 9; i++) step("auto");
    auto_en = 0;
    $display("txn auto_cycle: ch_sel=%0d", ch_sel);

    // Freeze holds the buffer
    vld = 1; freeze = 1; ch_data = {16'h1234, 16'h5678, 16'h9ABC};
    step("freeze"); vld = 0; step("freeze");
    freeze = 0; vld = 1; step("unfreeze"); vld = 0; step("unfreeze");
    $display("txn freeze: LED=0x%0h", LED);

    // Mid-SHOW reset, then calibration timeout and recovery
    async_reset("show_rst");
    for (int c = 1; c <= CAL_TMO; c++) begin
      step("tmo");
      if (c == CAL_TMO - 1) check_val("tmo.pre", cal_err, 0);
    end
    check_val("tmo.err", cal_err, 1);
    check_val("tmo.led", LED, 8'hFF);
    prev = 1; auto_en = 1; step("err_ign"); prev = 0; auto_en = 0;
    next = 1; step("err_next"); next = 0;
    step("recal");
    check_val("recal.strt", strt_cal, 1);
    check_val("recal.err", cal_err, 0);
    step("recal");
    $display("txn timeout_recover: cal_err=%0d", cal_err);

    // Randomized episodes, each starting from an asynchronous reset
    for (int ep = 0; ep < 16; ep++) begin
      async_reset("rnd");
      auto_en = $urandom_range(0, 1);
      for (int c = 0; c < 200; c++) begin
        cal_done = ($urandom_range(0, 24) == 0);
        vld      = ($urandom_range(0, 2) == 0);
        freeze   = ($urandom_range(0, 4) == 0);
        next     = ($urandom_range(0, 7) == 0);
        prev     = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
        shift    = 4'($urandom_range(0, 15));
        ch_data  = {16'($urandom()), 16'($urandom()), 16'($urandom())};
        step("rnd");
      end
      $display("txn random_episode %0d: mode=%0d ch_sel=%0d checks=%0d", ep, m_mode, ch_sel, n_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
